// File: rtl/ifetch_responder_pkg.sv
// ifetch_responder_pkg: shared constants, FSM encoding and byte-lane helper
// for the instruction-fetch responder. The HIT state exists only when the
// ICACHE_EN macro is defined.
package ifetch_responder_pkg;

   localparam int INST_W     = 32;
   localparam int INST_BYTES = INST_W / 8;
   // Cycles from address issue to the byte appearing on ram_din.
   localparam int RAM_RD_LAT = 1;

`ifdef ICACHE_EN
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_HIT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;
`endif

   // Insert one RAM byte into its little-endian lane of the assembly word.
   function automatic logic [INST_W-1:0] put_byte(input logic [INST_W-1:0] w,
                                                  input logic [1:0]        lane,
                                                  input logic [7:0]        b);
      logic [INST_W-1:0] r;
      r = w;
      r[{lane, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/ifetch_icache.sv
// ifetch_icache: direct-mapped, one-word-per-entry instruction cache.
// Combinational lookup, single-cycle fill. Only built when ICACHE_EN is set.
module ifetch_icache
   import ifetch_responder_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [31:0]       lk_addr,
   output logic              lk_hit,
   output logic [INST_W-1:0] lk_data,
   input  logic              fill_en,
   input  logic [31:2]       fill_addr,
   input  logic [INST_W-1:0] fill_data
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 32 - IDX_W - 2;

   logic [ENTRIES-1:0]  valid_q;
   logic [TAG_W-1:0]    tag_q  [ENTRIES];
   logic [INST_W-1:0]   data_q [ENTRIES];
   logic [IDX_W-1:0]    lk_idx;
   logic [IDX_W-1:0]    fill_idx;

   assign lk_idx   = lk_addr[IDX_W+1:2];
   assign fill_idx = fill_addr[IDX_W+1:2];

   // Misaligned addresses never hit; they always go to RAM.
   assign lk_hit  = (lk_addr[1:0] == 2'b00) && valid_q[lk_idx] &&
                    (tag_q[lk_idx] == lk_addr[31:IDX_W+2]);
   assign lk_data = data_q[lk_idx];

   // Valid bits are the only reset state; a fill marks its entry valid.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         valid_q <= '0;
      else if (fill_en)
         valid_q[fill_idx] <= 1'b1;
   end

   // Tag and data arrays, written on fill, contents ignored until valid.
   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         tag_q[fill_idx]  <= fill_addr[31:IDX_W+2];
         data_q[fill_idx] <= fill_data;
      end
   end

endmodule

// File: rtl/ifetch_responder.sv
// ifetch_responder: instruction-fetch responder. Builds each 32-bit
// instruction from four little-endian byte reads through the arbiter
// req/gnt handshake. Optional macro ICACHE_EN adds a direct-mapped icache
// (ifetch_icache) that answers aligned hits in one cycle.
module ifetch_responder
   import ifetch_responder_pkg::*;
#(
   parameter int ICACHE_IDX_W = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear,
   input  logic              if_enable,
   input  logic [31:0]       if_addr,
   output logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [31:0]       ram_a,
   input  logic [7:0]        ram_din
);

   state_t                       state_q, state_d;
   logic [31:0]                  base_q;
   logic [2:0]                   k_q;
   logic [RAM_RD_LAT-1:0]        vld_pipe;
   logic [RAM_RD_LAT-1:0][1:0]   lane_pipe;
   logic [INST_W-1:0]            buf_q;
   logic [INST_W-1:0]            inst_q;
   logic                         mem_req_q;

   logic                         accept;
   logic                         issue;
   logic                         cap_vld;
   logic [1:0]                   cap_lane;
   logic                         miss;
   logic                         ic_hit;
   logic [INST_W-1:0]            ic_data;

   assign accept   = (state_q == S_IDLE) && if_enable && !clear;
   // One byte address per granted cycle; k_q[2] marks all four issued.
   assign issue    = rdy_in && !clear && (state_q == S_FETCH) && mem_gnt && !k_q[2];
   assign cap_vld  = vld_pipe[RAM_RD_LAT-1];
   assign cap_lane = lane_pipe[RAM_RD_LAT-1];
   assign miss     = !ic_hit;

   assign mem_req  = mem_req_q;
   assign ram_a    = ((state_q == S_FETCH) && mem_gnt && !k_q[2]) ?
                     base_q + {30'b0, k_q[1:0]} : 32'h0;
   // The pulse cycle shows the fresh word; otherwise the last delivered one.
   assign inst     = inst_ready ? buf_q : inst_q;

`ifdef ICACHE_EN
   logic fill_en;
   // Only completed, unflushed, aligned RAM fetches fill the cache.
   assign fill_en = inst_ready && (state_q == S_DONE) && (base_q[1:0] == 2'b00);

   ifetch_icache #(.IDX_W(ICACHE_IDX_W)) u_icache (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .lk_addr   (if_addr),
      .lk_hit    (ic_hit),
      .lk_data   (ic_data),
      .fill_en   (fill_en),
      .fill_addr (base_q[31:2]),
      .fill_data (buf_q)
   );
`else
   logic [31:0] unused_cfg;
   assign unused_cfg = 32'(ICACHE_IDX_W);
   assign ic_hit     = 1'b0;
   assign ic_data    = '0;
`endif

   // State register; rdy_in low freezes the FSM.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         state_q <= S_IDLE;
      else if (rdy_in)
         state_q <= state_d;
   end

   // Next state and response pulse; clear overrides everything.
   always_comb begin
      state_d    = state_q;
      inst_ready = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
`ifdef ICACHE_EN
                  state_d = ic_hit ? S_HIT : S_FETCH;
`else
                  state_d = S_FETCH;
`endif
               end
            end
            S_FETCH: begin
               if (cap_vld && (cap_lane == 2'd3))
                  state_d = S_DONE;
            end
            S_DONE: begin
               inst_ready = rdy_in;
               state_d    = S_IDLE;
            end
`ifdef ICACHE_EN
            S_HIT: begin
               inst_ready = rdy_in;
               state_d    = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath: address counter, read-return pipe, byte assembly, request.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         base_q    <= '0;
         k_q       <= '0;
         vld_pipe  <= '0;
         lane_pipe <= '0;
         buf_q     <= '0;
         inst_q    <= '0;
         mem_req_q <= 1'b0;
      end else if (rdy_in) begin
         if (inst_ready)
            inst_q <= buf_q;
         if (clear) begin
            // Dropping the pipe valid bits discards any byte still in flight.
            k_q       <= '0;
            vld_pipe  <= '0;
            buf_q     <= '0;
            mem_req_q <= 1'b0;
         end else begin
            vld_pipe[0]  <= issue;
            lane_pipe[0] <= k_q[1:0];
            for (int i = 1; i < RAM_RD_LAT; i++) begin
               vld_pipe[i]  <= vld_pipe[i-1];
               lane_pipe[i] <= lane_pipe[i-1];
            end
            if (accept) begin
               base_q    <= if_addr;
               k_q       <= '0;
               mem_req_q <= miss;
               buf_q     <= miss ? '0 : ic_data;
            end
            if (issue) begin
               k_q <= k_q + 3'd1;
               if (k_q[1:0] == 2'd3)
                  mem_req_q <= 1'b0;
            end
            if (cap_vld)
               buf_q <= put_byte(buf_q, cap_lane, ram_din);
         end
      end
   end

endmodule

// File: tb/tb_ifetch_responder.sv
// tb_ifetch_responder: table-driven fetch vectors plus hand-written clear
// sequences; expected addresses and words go into scoreboard queues when a
// fetch is driven and are popped when the DUT issues or responds.
module tb_ifetch_responder;

   localparam logic [31:0] NONE = 32'hDEAD_BEE0;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        clear = 1'b0;
   logic        if_enable = 1'b0;
   logic [31:0] if_addr = '0;
   logic        inst_ready;
   logic [31:0] inst;
   logic        mem_req;
   logic        mem_gnt = 1'b1;
   logic [31:0] ram_a;
   logic [7:0]  ram_din = '0;

   ifetch_responder #(.ICACHE_IDX_W(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .if_enable(if_enable), .if_addr(if_addr), .inst_ready(inst_ready),
      .inst(inst), .mem_req(mem_req), .mem_gnt(mem_gnt), .ram_a(ram_a),
      .ram_din(ram_din)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Byte-wide RAM: preloaded bytes, otherwise a fixed address pattern.
   logic [7:0] mem [logic [31:0]];
   function automatic logic [7:0] rb(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'h5A;
   endfunction
   always @(posedge clk_in) if (rdy_in) ram_din <= rb(ram_a);

   typedef struct {
      logic [31:0] addr;
      logic [31:0] stall_at;
      int          stall_len;
      int          rdy_at;
      int          rdy_len;
      bit          miss;
      logic [31:0] exp_inst;
      int          exp_lat;
   } fvec_t;

   fvec_t tab[4];
   fvec_t ic_tab[4];

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_inst_q[$];
   logic [31:0] last_inst = '0;
   int          n_ready = 0;
   int          ready_cyc = 0;
   logic [31:0] stall_addr = NONE;
   int          stall_len = 0;
   int          gap = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Start of a cycle: just after the edge, update the grant.
   task automatic cyc_begin();
      @(posedge clk_in); #1;
      if (gap > 0) begin
         mem_gnt = 1'b0;
         gap--;
      end else begin
         mem_gnt = 1'b1;
      end
   endtask

   // Middle of a cycle: observe issues and responses against the scoreboard.
   task automatic cyc_end();
      logic [31:0] e;
      @(negedge clk_in);
      if (rst_in && rdy_in && !clear && mem_req && mem_gnt) begin
         chk("issue expected", 32'(exp_addr_q.size() != 0), 32'd1);
         if (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            chk("ram_a", ram_a, e);
         end
         if (ram_a == stall_addr && stall_len > 0) gap = stall_len;
      end
      if (inst_ready) begin
         n_ready++;
         ready_cyc = cyc;
         chk("ready expected", 32'(exp_inst_q.size() != 0), 32'd1);
         if (exp_inst_q.size() != 0) begin
            e = exp_inst_q.pop_front();
            chk("inst", inst, e);
            last_inst = e;
         end
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_begin();
         cyc_end();
      end
   endtask

   task automatic run_fetch(input fvec_t v);
      int acc, n0;
      logic req_seen;
      cyc_begin();
      if_enable  = 1'b1;
      if_addr    = v.addr;
      stall_addr = v.stall_at;
      stall_len  = v.stall_len;
      acc = cyc;
      n0  = n_ready;
      exp_inst_q.push_back(v.exp_inst);
      if (v.miss)
         for (int j = 0; j < 4; j++) exp_addr_q.push_back(v.addr + 32'(j));
      cyc_end();
      req_seen = mem_req;
      for (int i = 1; i < 40 && n_ready == n0; i++) begin
         cyc_begin();
         rdy_in = !(v.rdy_len > 0 && i >= v.rdy_at && i < v.rdy_at + v.rdy_len);
         cyc_end();
         req_seen = req_seen | mem_req;
      end
      rdy_in = 1'b1;
      chk("ready count", 32'(n_ready - n0), 32'd1);
      if (n_ready != n0) chk("latency", 32'(ready_cyc - acc), 32'(v.exp_lat));
      if (!v.miss) chk("hit mem_req", 32'(req_seen), 32'd0);
      stall_addr = NONE;
      stall_len  = 0;
   endtask

   initial begin
      int acc, n0;
      mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'hA0; mem[32'h103] = 8'h00;
      mem[32'h104] = 8'h93; mem[32'h105] = 8'h02; mem[32'h106] = 8'h10; mem[32'h107] = 8'h00;
      mem[32'h200] = 8'hB7; mem[32'h201] = 8'h12; mem[32'h202] = 8'h00; mem[32'h203] = 8'h00;

      //            addr          stall_at  len rdy_at len miss exp_inst      lat
      tab[0] = '{32'h0000_0100, NONE,        0, 0, 0, 1'b1, 32'h00A0_0513, 6};
      tab[1] = '{32'h0000_0104, 32'h105,     2, 0, 0, 1'b1, 32'h0010_0293, 8};
      tab[2] = '{32'hFFFF_FFFE, NONE,        0, 3, 3, 1'b1, 32'h5B5A_A5A4, 9};
      tab[3] = '{32'h0000_02A2, NONE,        0, 0, 0, 1'b1, 32'hFFFE_F9F8, 6};

      ic_tab[0] = '{32'h0000_0100, NONE, 0, 0, 0, 1'b1, 32'h00A0_0513, 6};
`ifdef ICACHE_EN
      ic_tab[1] = '{32'h0000_0100, NONE, 0, 0, 0, 1'b0, 32'h00A0_0513, 1};
`else
      ic_tab[1] = '{32'h0000_0100, NONE, 0, 0, 0, 1'b1, 32'h00A0_0513, 6};
`endif
      ic_tab[2] = '{32'h0000_0140, NONE, 0, 0, 0, 1'b1, 32'h1918_1B1A, 6};
      ic_tab[3] = '{32'h0000_0100, NONE, 0, 0, 0, 1'b1, 32'h00A0_0513, 6};

      // Reset state
      #2 rst_in = 1'b0;
      step(3);
      chk("rst inst_ready", 32'(inst_ready), 32'd0);
      chk("rst inst", inst, 32'h0);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst ram_a", ram_a, 32'h0);
      cyc_begin();
      rst_in = 1'b1;
      cyc_end();
      step(2);

      // Back-to-back table fetches: each accepted the cycle after the pulse.
      foreach (tab[i]) run_fetch(tab[i]);
      cyc_begin(); if_enable = 1'b0; cyc_end();
      step(2);

      // Clear mid-fetch after byte 1 is captured.
      cyc_begin();
      if_enable = 1'b1; if_addr = 32'h180; acc = cyc; n0 = n_ready;
      for (int j = 0; j < 3; j++) exp_addr_q.push_back(32'h180 + 32'(j));
      cyc_end();
      step(3);
      cyc_begin(); clear = 1'b1; if_enable = 1'b0; cyc_end();
      cyc_begin(); clear = 1'b0; cyc_end();
      chk("clear mem_req", 32'(mem_req), 32'd0);
      step(8);
      chk("clear no ready", 32'(n_ready - n0), 32'd0);
      chk("clear addr left", 32'(exp_addr_q.size()), 32'd0);
      chk("clear cycles", 32'(cyc - acc), 32'd13);

      // Fresh fetch after the flush returns correct data.
      begin
         fvec_t v;
         v = '{32'h0000_0200, NONE, 0, 0, 0, 1'b1, 32'h0000_12B7, 6};
         run_fetch(v);
      end
      cyc_begin(); if_enable = 1'b0; cyc_end();
      step(2);

      // Clear coinciding with DONE: no pulse, inst keeps last word.
      cyc_begin();
      if_enable = 1'b1; if_addr = 32'h300; n0 = n_ready;
      for (int j = 0; j < 4; j++) exp_addr_q.push_back(32'h300 + 32'(j));
      cyc_end();
      step(5);
      cyc_begin(); clear = 1'b1; if_enable = 1'b0; cyc_end();
      chk("done+clear inst_ready", 32'(inst_ready), 32'd0);
      chk("done+clear inst", inst, last_inst);
      cyc_begin(); clear = 1'b0; cyc_end();
      step(6);
      chk("done+clear no ready", 32'(n_ready - n0), 32'd0);
      chk("done+clear addr left", 32'(exp_addr_q.size()), 32'd0);
      chk("inst held", inst, last_inst);

      // Repeat fetch (hit when cached), conflicting tag, then evicted line.
      foreach (ic_tab[i]) run_fetch(ic_tab[i]);
      cyc_begin(); if_enable = 1'b0; cyc_end();
      step(4);
      chk("scoreboard empty", 32'(exp_addr_q.size() + exp_inst_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
